// File: rtl/compressor_pkg.sv
// Shared constants, state encoding and popcount helper for the 8:2 compressor
// error-monitoring blocks.
package compressor_pkg;

  localparam int IN_W     = 8;
  localparam int ED_W     = 4;
  localparam int APPROX_W = 2;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    REPORT
  } state_t;

  function automatic logic [ED_W-1:0] popcount8(input logic [IN_W-1:0] v);
    logic [ED_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < IN_W; i++) begin
      cnt = cnt + ED_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/compressor_error_distance.sv
// Combinational error distance between an 8-bit vector's popcount and the
// 2-bit {carry,sum} value a compressor produced for it.
module compressor_error_distance
  import compressor_pkg::*;
(
  input  logic [IN_W-1:0]     i_in,
  input  logic [APPROX_W-1:0] i_approx,
  output logic [ED_W-1:0]     o_ed,
  output logic                o_err
);

  logic [ED_W-1:0] w_exact;
  logic [ED_W-1:0] w_approx;

  assign w_exact  = popcount8(i_in);
  assign w_approx = {{(ED_W-APPROX_W){1'b0}}, i_approx};
  assign o_ed     = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);
  assign o_err    = |o_ed;

endmodule

// File: rtl/compressor_error_monitor.sv
// Per-frame error statistics for a compressor under test: two-stage beat
// pipeline feeding saturating accumulators, one result record per frame.
module compressor_error_monitor
  import compressor_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int ACC_W = CNT_W + 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_W-1:0]     s_in,
  input  logic [APPROX_W-1:0] s_approx,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CNT_W-1:0]    m_samples,
  output logic [CNT_W-1:0]    m_err_count,
  output logic [ACC_W-1:0]    m_err_dist_sum,
  output logic [ED_W-1:0]     m_max_err,
  output logic                m_sat
);

  localparam int SUM_W = ACC_W + 1;

  state_t r_state, w_state_nxt;

  logic            w_accept, w_report_done;
  logic [ED_W-1:0] w_ed;
  logic            w_err;

  logic            r_s1_valid, r_s1_err, r_s1_last;
  logic [ED_W-1:0] r_s1_ed;

  logic [CNT_W-1:0] r_samples, r_err_count, w_samples_nxt, w_err_count_nxt;
  logic [ACC_W-1:0] r_dist_sum, w_dist_sum_nxt;
  logic [ED_W-1:0]  r_max_err, w_max_err_nxt;
  logic             r_sat, w_sat_nxt;
  logic [SUM_W-1:0] w_sum_ext;

  compressor_error_distance u_ed (
    .i_in     (s_in),
    .i_approx (s_approx),
    .o_ed     (w_ed),
    .o_err    (w_err)
  );

  // rst gates s_ready directly so no beat is taken while reset is held.
  assign s_ready       = (r_state == ACCUM) && !rst;
  assign w_accept      = s_valid && s_ready;
  assign m_valid       = (r_state == REPORT);
  assign w_report_done = m_valid && m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ed    <= '0;
      r_s1_err   <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ed   <= w_ed;
        r_s1_err  <= w_err;
        r_s1_last <= s_last;
      end
    end
  end

  assign w_sum_ext = {1'b0, r_dist_sum} + SUM_W'(r_s1_ed);

  // NOTE: every variable gets its hold value first so no path through the
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    w_samples_nxt   = r_samples;
    w_err_count_nxt = r_err_count;
    w_dist_sum_nxt  = r_dist_sum;
    w_max_err_nxt   = r_max_err;
    w_sat_nxt       = r_sat;
    if (r_s1_valid) begin
      if (&r_samples) w_sat_nxt = 1'b1;
      else            w_samples_nxt = r_samples + CNT_W'(1);
      if (r_s1_err) begin
        if (&r_err_count) w_sat_nxt = 1'b1;
        else              w_err_count_nxt = r_err_count + CNT_W'(1);
      end
      if (w_sum_ext[ACC_W]) begin
        w_dist_sum_nxt = '1;
        w_sat_nxt      = 1'b1;
      end else begin
        w_dist_sum_nxt = w_sum_ext[ACC_W-1:0];
      end
      if (r_s1_ed > r_max_err) w_max_err_nxt = r_s1_ed;
    end
    if (w_report_done) begin
      w_samples_nxt   = '0;
      w_err_count_nxt = '0;
      w_dist_sum_nxt  = '0;
      w_max_err_nxt   = '0;
      w_sat_nxt       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samples   <= '0;
      r_err_count <= '0;
      r_dist_sum  <= '0;
      r_max_err   <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_samples   <= w_samples_nxt;
      r_err_count <= w_err_count_nxt;
      r_dist_sum  <= w_dist_sum_nxt;
      r_max_err   <= w_max_err_nxt;
      r_sat       <= w_sat_nxt;
    end
  end

  // DRAIN holds for the single cycle in which stage 2 absorbs the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept && s_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_s1_last)          w_state_nxt = REPORT;
      REPORT:  if (m_ready)            w_state_nxt = ACCUM;
      default:                         w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  assign m_samples      = r_samples;
  assign m_err_count    = r_err_count;
  assign m_err_dist_sum = r_dist_sum;
  assign m_max_err      = r_max_err;
  assign m_sat          = r_sat;

endmodule
